// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry path: key codes, ALU opcodes,
// sequencer states and key classification helpers.
package calc_pkg;

  localparam int unsigned DIGITS_DEF = 4;

  // Non-digit key codes (0x0-0x9 are digits)
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // ALU opcodes
  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_MUL = 2'b10;
  localparam logic [1:0] OPC_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_ISSUE,
    ST_WAIT_RES
  } state_t;

  typedef enum logic [1:0] {
    KC_DIGIT,
    KC_OPER,
    KC_EQ,
    KC_CLR
  } key_class_t;

  function automatic key_class_t classify(input logic [3:0] code);
    key_class_t kc;
    if (code <= 4'h9)        kc = KC_DIGIT;
    else if (code == KEY_EQ)  kc = KC_EQ;
    else if (code == KEY_CLR) kc = KC_CLR;
    else                      kc = KC_OPER;
    return kc;
  endfunction

  function automatic logic [1:0] key_to_opcode(input logic [3:0] code);
    logic [1:0] opc;
    unique case (code)
      KEY_SUB: opc = OPC_SUB;
      KEY_MUL: opc = OPC_MUL;
      KEY_DIV: opc = OPC_DIV;
      default: opc = OPC_ADD;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/calc_entry_seq_key_accept.sv
// Key acceptor: turns a held key-valid level into exactly one accept pulse
// after DEBOUNCE consecutive high cycles. A new accept needs the key to be
// released for at least one cycle. The accept pulse is combinational from
// the counter so the consumer can register the key on the same edge.
module key_accept #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       flush,
  output logic       accept,
  output logic [3:0] code
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;
  logic          held;

  // Accept fires on the cycle the run of high samples reaches DEBOUNCE
  always_comb begin
    accept = key_valid && !held && !flush && (cnt == LAST);
    code   = key_code;
  end

  // Debounce counter and release latch; reset and flush both demand a release
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt  <= '0;
      held <= 1'b1;
    end else if (!key_valid) begin
      cnt  <= '0;
      held <= 1'b0;
    end else begin
      if (accept || flush) held <= 1'b1;
      if (flush)
        cnt <= '0;
      else if (!held && cnt != LAST)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/calc_entry_seq.sv
// Calculator operand entry sequencer: assembles two BCD operands and an
// opcode from debounced keys, offers them to the ALU over valid/ready and
// captures the result back into operand A for chaining.
module calc_entry_seq
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS   = DIGITS_DEF,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  KEY_VALID,
  input  logic [3:0]            KEY_CODE,
  output logic                  KBD_EN,
  output logic [4*DIGITS-1:0]   OP_A,
  output logic [4*DIGITS-1:0]   OP_B,
  output logic [1:0]            OPCODE,
  output logic                  CALC_VALID,
  input  logic                  CALC_READY,
  input  logic                  RES_VALID,
  input  logic [4*DIGITS-1:0]   RES,
  output logic [4*DIGITS-1:0]   DISP_DATA,
  output logic                  DIG_OVF
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  state_t        state, state_n;
  logic [W-1:0]  a, a_n, b, b_n;
  logic [1:0]    opc, opc_n;
  logic [CW-1:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic          fresh, fresh_n;
  logic          dig_ovf_n;
  logic          calc_valid, kbd_en;
  logic [W-1:0]  disp;
  logic          entry;
  logic          key_acc;
  logic [3:0]    key_code_acc;
  logic [W-1:0]  digit_w;
  logic [W-1:0]  a_base;
  logic [CW-1:0] cnt_base;

  assign entry = (state == ST_ENTER_A) || (state == ST_ENTER_B);

  key_accept #(.DEBOUNCE(DEBOUNCE)) u_key_accept (
    .CLK       (CLK),
    .RESET     (RESET),
    .key_valid (KEY_VALID),
    .key_code  (KEY_CODE),
    .flush     (!entry),
    .accept    (key_acc),
    .code      (key_code_acc)
  );

  // Next-state and datapath updates for each accepted key / handshake
  always_comb begin
    state_n   = state;
    a_n       = a;
    b_n       = b;
    opc_n     = opc;
    cnt_a_n   = cnt_a;
    cnt_b_n   = cnt_b;
    fresh_n   = fresh;
    dig_ovf_n = 1'b0;
    digit_w   = W'(key_code_acc);
    a_base    = a;
    cnt_base  = cnt_a;

    unique case (state)
      ST_ENTER_A: begin
        if (key_acc) begin
          unique case (classify(key_code_acc))
            KC_DIGIT: begin
              // A result left in A is discarded by the first new digit
              if (fresh) begin
                a_base   = '0;
                cnt_base = '0;
                fresh_n  = 1'b0;
              end
              if (cnt_base < FULL) begin
                a_n     = (a_base << 4) | digit_w;
                cnt_a_n = cnt_base + CW'(1);
              end else begin
                a_n       = a_base;
                cnt_a_n   = cnt_base;
                dig_ovf_n = 1'b1;
              end
            end
            KC_OPER: begin
              opc_n   = key_to_opcode(key_code_acc);
              b_n     = '0;
              cnt_b_n = '0;
              fresh_n = 1'b0;
              state_n = ST_ENTER_B;
            end
            KC_CLR: begin
              a_n     = '0;
              cnt_a_n = '0;
              fresh_n = 1'b0;
            end
            default: ;
          endcase
        end
      end

      ST_ENTER_B: begin
        if (key_acc) begin
          unique case (classify(key_code_acc))
            KC_DIGIT: begin
              if (cnt_b < FULL) begin
                b_n     = (b << 4) | digit_w;
                cnt_b_n = cnt_b + CW'(1);
              end else begin
                dig_ovf_n = 1'b1;
              end
            end
            KC_OPER: begin
              if (cnt_b == '0) opc_n = key_to_opcode(key_code_acc);
            end
            KC_EQ: begin
              if (cnt_b != '0) state_n = ST_ISSUE;
            end
            KC_CLR: begin
              a_n     = '0;
              b_n     = '0;
              cnt_a_n = '0;
              cnt_b_n = '0;
              opc_n   = OPC_ADD;
              fresh_n = 1'b0;
              state_n = ST_ENTER_A;
            end
            default: ;
          endcase
        end
      end

      ST_ISSUE: begin
        if (calc_valid && CALC_READY) state_n = ST_WAIT_RES;
      end

      ST_WAIT_RES: begin
        if (RES_VALID) begin
          a_n     = RES;
          fresh_n = 1'b1;
          cnt_a_n = '0;
          b_n     = '0;
          cnt_b_n = '0;
          state_n = ST_ENTER_A;
        end
      end

      default: state_n = ST_ENTER_A;
    endcase
  end

  // State, operand registers and registered outputs derived from next state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_ENTER_A;
      a          <= '0;
      b          <= '0;
      opc        <= OPC_ADD;
      cnt_a      <= '0;
      cnt_b      <= '0;
      fresh      <= 1'b0;
      calc_valid <= 1'b0;
      kbd_en     <= 1'b0;
      disp       <= '0;
      DIG_OVF    <= 1'b0;
    end else begin
      state      <= state_n;
      a          <= a_n;
      b          <= b_n;
      opc        <= opc_n;
      cnt_a      <= cnt_a_n;
      cnt_b      <= cnt_b_n;
      fresh      <= fresh_n;
      calc_valid <= (state_n == ST_ISSUE);
      kbd_en     <= (state_n == ST_ENTER_A) || (state_n == ST_ENTER_B);
      disp       <= ((state_n == ST_ENTER_B) && (cnt_b_n != '0)) ? b_n : a_n;
      DIG_OVF    <= dig_ovf_n;
    end
  end

  assign OP_A       = a;
  assign OP_B       = b;
  assign OPCODE     = opc;
  assign CALC_VALID = calc_valid;
  assign KBD_EN     = kbd_en;
  assign DISP_DATA  = disp;

endmodule

// File: tb/tb_calc_entry_seq.sv
// Directed bench for calc_entry_seq with hand-computed expectations.
module tb_calc_entry_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic        KBD_EN;
  logic [15:0] OP_A, OP_B;
  logic [1:0]  OPCODE;
  logic        CALC_VALID;
  logic        CALC_READY;
  logic        RES_VALID;
  logic [15:0] RES;
  logic [15:0] DISP_DATA;
  logic        DIG_OVF;

  int unsigned errors = 0;
  int unsigned checks = 0;

  calc_entry_seq #(.DIGITS(4), .DEBOUNCE(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .KEY_VALID  (KEY_VALID),
    .KEY_CODE   (KEY_CODE),
    .KBD_EN     (KBD_EN),
    .OP_A       (OP_A),
    .OP_B       (OP_B),
    .OPCODE     (OPCODE),
    .CALC_VALID (CALC_VALID),
    .CALC_READY (CALC_READY),
    .RES_VALID  (RES_VALID),
    .RES        (RES),
    .DISP_DATA  (DISP_DATA),
    .DIG_OVF    (DIG_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] code, input int unsigned hold = 6);
    KEY_VALID = 1'b1;
    KEY_CODE  = code;
    tick(hold);
    KEY_VALID = 1'b0;
    tick(2);
  endtask

  initial begin
    RESET = 1'b1; KEY_VALID = 1'b0; KEY_CODE = 4'h0;
    CALC_READY = 1'b0; RES_VALID = 1'b0; RES = 16'h0;
    tick(3);
    chk("rst_kbd_en", 16'(KBD_EN), 16'h0);
    chk("rst_op_a", OP_A, 16'h0);
    chk("rst_calc_valid", 16'(CALC_VALID), 16'h0);
    chk("rst_disp", DISP_DATA, 16'h0);
    chk("rst_dig_ovf", 16'(DIG_OVF), 16'h0);
    RESET = 1'b0;
    tick(1);
    chk("kbd_en_after_rst", 16'(KBD_EN), 16'h1);

    // Key 1 with latency check: visible at t+DEBOUNCE, not before
    KEY_VALID = 1'b1; KEY_CODE = 4'h1;
    tick(3);
    chk("latency_early", DISP_DATA, 16'h0);
    tick(1);
    chk("latency_on_time", DISP_DATA, 16'h1);
    tick(2); KEY_VALID = 1'b0; tick(2);

    press(4'h2);
    chk("a_12", OP_A, 16'h0012);
    press(4'hA);
    chk("opc_add", 16'(OPCODE), 16'h0);
    chk("disp_a_in_b_empty", DISP_DATA, 16'h0012);
    press(4'h3);
    chk("b_3", OP_B, 16'h0003);
    chk("disp_b", DISP_DATA, 16'h0003);
    press(4'hE);
    chk("issue_valid", 16'(CALC_VALID), 16'h1);

    // ALU stalls; key 7 during ISSUE must be discarded
    press(4'h7);
    tick(2);
    chk("stall_valid", 16'(CALC_VALID), 16'h1);
    chk("stall_op_a", OP_A, 16'h0012);
    chk("stall_op_b", OP_B, 16'h0003);
    chk("stall_opc", 16'(OPCODE), 16'h0);
    chk("stall_kbd_en", 16'(KBD_EN), 16'h0);

    // Handshake with a simultaneous (ignored) result strobe
    CALC_READY = 1'b1; RES_VALID = 1'b1; RES = 16'h0099;
    tick(1);
    CALC_READY = 1'b0;
    chk("valid_drop", 16'(CALC_VALID), 16'h0);
    chk("same_cycle_res_ignored", OP_A, 16'h0012);
    RES = 16'h0015;
    tick(1);
    RES_VALID = 1'b0;
    chk("res_to_a", OP_A, 16'h0015);
    chk("res_clears_b", OP_B, 16'h0);
    chk("res_kbd_en", 16'(KBD_EN), 16'h1);

    // Chain: operator on the result
    press(4'hB);
    press(4'h5);
    press(4'hE);
    chk("chain_op_a", OP_A, 16'h0015);
    chk("chain_op_b", OP_B, 16'h0005);
    chk("chain_opc", 16'(OPCODE), 16'h1);
    chk("chain_valid", 16'(CALC_VALID), 16'h1);
    CALC_READY = 1'b1; tick(1); CALC_READY = 1'b0;
    RES_VALID = 1'b1; RES = 16'h0015; tick(1); RES_VALID = 1'b0;
    press(4'h9);
    chk("fresh_digit", OP_A, 16'h0009);

    // Saturation at four digits
    press(4'hF);
    chk("clear_a", OP_A, 16'h0);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("a_1234", OP_A, 16'h1234);
    KEY_VALID = 1'b1; KEY_CODE = 4'h5;
    tick(3);
    chk("ovf_not_yet", 16'(DIG_OVF), 16'h0);
    tick(1);
    chk("ovf_pulse", 16'(DIG_OVF), 16'h1);
    chk("ovf_a_kept", OP_A, 16'h1234);
    tick(1);
    chk("ovf_one_cycle", 16'(DIG_OVF), 16'h0);
    tick(1); KEY_VALID = 1'b0; tick(2);

    // Short press rejected, long press accepted exactly once
    press(4'hF);
    press(4'h6, 3);
    chk("short_press", OP_A, 16'h0);
    press(4'h6, 50);
    chk("long_press_once", OP_A, 16'h0006);

    // Operator replacement, equals with empty B, clear from ENTER_B
    press(4'hF);
    press(4'h8);
    press(4'hC);
    chk("opc_mul", 16'(OPCODE), 16'h2);
    press(4'hD);
    chk("opc_div", 16'(OPCODE), 16'h3);
    press(4'hE);
    chk("eq_empty_b", 16'(CALC_VALID), 16'h0);
    chk("disp_a_8", DISP_DATA, 16'h0008);
    press(4'hF);
    chk("clr_b_a", OP_A, 16'h0);
    chk("clr_b_opc", 16'(OPCODE), 16'h0);
    chk("clr_b_kbd_en", 16'(KBD_EN), 16'h1);

    // Reset during ISSUE, with a key held through reset release
    press(4'h2); press(4'hA); press(4'h4); press(4'hE);
    chk("pre_rst_valid", 16'(CALC_VALID), 16'h1);
    KEY_VALID = 1'b1; KEY_CODE = 4'h9;
    RESET = 1'b1;
    tick(1);
    chk("mid_rst_valid", 16'(CALC_VALID), 16'h0);
    chk("mid_rst_a", OP_A, 16'h0);
    chk("mid_rst_b", OP_B, 16'h0);
    chk("mid_rst_kbd_en", 16'(KBD_EN), 16'h0);
    chk("mid_rst_disp", DISP_DATA, 16'h0);
    RESET = 1'b0;
    tick(10);
    chk("held_key_ignored", OP_A, 16'h0);
    chk("post_rst_kbd_en", 16'(KBD_EN), 16'h1);
    KEY_VALID = 1'b0; tick(2);
    press(4'h9);
    chk("after_release", OP_A, 16'h0009);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
